// File: rtl/vector_norm_pkg.sv
// vector_norm_pkg
//   Shared definitions for the vector_norm coprocessor: FSM state encoding,
//   a constant-evaluable clog2 helper, and the derived width expressions
//   (sum-of-squares width SW and root width R) used by the RTL and the bench.
// Ports: none (package).
package vector_norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SQRT = 2'd2,
        FIN  = 2'd3
    } state_t;

    // Smallest r with 2**r >= v; clog2_f(1) = 0.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

    // Sum-of-squares width: N*(2**W-1)**2 always fits.
    function automatic int sw_f(input int w, input int n);
        return 2 * w + clog2_f(n);
    endfunction

    // Root width, also the number of square-root iterations.
    function automatic int r_f(input int w, input int n);
        return (sw_f(w, n) + 1) / 2;
    endfunction

endpackage

// File: rtl/vector_norm_if.sv
// vector_norm_if
//   Start/busy handshake bundle for the vector_norm coprocessor.
//   Ports (signals):
//     start_i  request, taken only while busy_o = 0
//     mode_i   0 = norm, 1 = sum of squares
//     vec_bi   N packed W-bit elements, element k at [k*W +: W]
//     busy_o   operation in progress
//     valid_o  one-cycle pulse, y_bo freshly updated
//     y_bo     result (SW bits)
//   Modports: master drives the request side, slave is the coprocessor.
interface vector_norm_if #(
    parameter int W = 8,
    parameter int N = 4
);
    import vector_norm_pkg::*;

    localparam int SW = sw_f(W, N);

    logic              start_i;
    logic              mode_i;
    logic [N*W-1:0]    vec_bi;
    logic              busy_o;
    logic              valid_o;
    logic [SW-1:0]     y_bo;

    modport master (
        output start_i, mode_i, vec_bi,
        input  busy_o, valid_o, y_bo
    );

    modport slave (
        input  start_i, mode_i, vec_bi,
        output busy_o, valid_o, y_bo
    );

endinterface

// File: rtl/vector_norm_sq.sv
// sq_shift_add
//   Start/busy shift-add squarer. A start loads the operand; the product
//   builds up one multiplier bit per cycle over W cycles.
//   Ports:
//     clk_i, rst_ni  clock, async active-low reset
//     start_i        load a_i and begin (also restarts a running product)
//     a_i            W-bit unsigned operand
//     busy_o         product in progress
//     last_o         down-counter at terminal count; with busy_o marks the
//                    final cycle, in which p_o is the complete square
//     p_o            2W-bit running product including this cycle's term
module sq_shift_add
    import vector_norm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [W-1:0]     a_i,
    output logic             busy_o,
    output logic             last_o,
    output logic [2*W-1:0]   p_o
);

    localparam int CW = (W > 1) ? clog2_f(W) : 1;

    logic              busy_q;
    logic [CW-1:0]     cnt_q;
    logic [2*W-1:0]    mcand_q;
    logic [W-1:0]      mplier_q;
    logic [2*W-1:0]    acc_q;
    logic [2*W-1:0]    term;

    assign term   = mplier_q[0] ? mcand_q : '0;
    // Combinational final add lets the caller consume the square in the
    // last busy cycle instead of one cycle later.
    assign p_o    = acc_q + term;
    assign busy_o = busy_q;
    assign last_o = (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            busy_q   <= 1'b1;
            cnt_q    <= CW'(W - 1);
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= a_i;
            acc_q    <= '0;
        end else if (busy_q) begin
            acc_q    <= p_o;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_norm.sv
// vector_norm
//   Multi-cycle coprocessor: floor(sqrt(sum x[k]^2)) or the raw sum of
//   squares of an N-element unsigned vector. One shared shift-add squarer,
//   one bit-serial restoring square root; latency is data-independent.
//   Ports:
//     clk_i   clock
//     rst_ni  async active-low reset, aborts any job in flight
//     bus     vector_norm_if slave: start_i, mode_i, vec_bi in;
//             busy_o, valid_o, y_bo out
//
//   state | meaning
//   IDLE  | waiting for start_i; valid_o pulses here right after FIN
//   MUL   | squaring element k (W cycles each), accumulating, N elements
//   SQRT  | restoring root, one bit per cycle MSB first, R cycles
//   FIN   | register y_bo, return to IDLE
module vector_norm
    import vector_norm_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    vector_norm_if.slave bus
);

    localparam int SW = sw_f(W, N);
    localparam int R  = r_f(W, N);
    localparam int IW = (N > 1) ? clog2_f(N) : 1;
    localparam int RW = (R > 1) ? clog2_f(R) : 1;

    state_t            state_q, state_d;
    logic              mode_q;
    logic [N*W-1:0]    vec_q;      // elements still to be squared, next at LSB
    logic [IW-1:0]     elem_q;     // elements remaining after the current one
    logic [SW-1:0]     acc_q;
    logic [2*R-1:0]    rad_q;
    logic [R+1:0]      rem_q;
    logic [R-1:0]      root_q;
    logic [RW-1:0]     bit_q;
    logic [SW-1:0]     y_q;
    logic              valid_q;

    logic              sq_start;
    logic [W-1:0]      sq_a;
    logic              sq_busy;
    logic              sq_last;
    logic [2*W-1:0]    sq_p;
    logic              sq_done;
    logic [SW-1:0]     acc_n;

    logic [R+1:0]      rem_sh;
    logic [R+1:0]      trial;
    logic              ge;

    sq_shift_add #(.W(W)) u_sq (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (sq_start),
        .a_i     (sq_a),
        .busy_o  (sq_busy),
        .last_o  (sq_last),
        .p_o     (sq_p)
    );

    assign sq_done = sq_busy & sq_last;
    assign acc_n   = acc_q + SW'(sq_p);

    // Element 0 goes to the squarer straight from the bus in the accept
    // cycle, so squaring starts with no setup cycle.
    assign sq_a = (state_q == IDLE) ? bus.vec_bi[W-1:0] : vec_q[W-1:0];

    // Restoring root step: bring down two radicand bits, try 4*root+1.
    assign rem_sh = (rem_q << 2) | (R + 2)'(rad_q[2*R-1 -: 2]);
    assign trial  = {root_q, 2'b01};
    assign ge     = (rem_sh >= trial);

    always_comb begin
        state_d  = state_q;
        sq_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d  = MUL;
                    sq_start = 1'b1;
                end
            end
            MUL: begin
                if (sq_done) begin
                    if (elem_q != '0) begin
                        sq_start = 1'b1;
                    end else begin
                        state_d = mode_q ? FIN : SQRT;
                    end
                end
            end
            SQRT: begin
                if (bit_q == '0) state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= 1'b0;
            vec_q   <= '0;
            elem_q  <= '0;
            acc_q   <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            bit_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= (state_q == FIN);
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        mode_q <= bus.mode_i;
                        vec_q  <= bus.vec_bi >> W;
                        elem_q <= IW'(N - 1);
                        acc_q  <= '0;
                    end
                end
                MUL: begin
                    if (sq_done) begin
                        acc_q <= acc_n;
                        vec_q <= vec_q >> W;
                        if (elem_q != '0) begin
                            elem_q <= elem_q - 1'b1;
                        end else begin
                            rad_q  <= (2 * R)'(acc_n);
                            rem_q  <= '0;
                            root_q <= '0;
                            bit_q  <= RW'(R - 1);
                        end
                    end
                end
                SQRT: begin
                    rad_q  <= rad_q << 2;
                    rem_q  <= ge ? (rem_sh - trial) : rem_sh;
                    root_q <= R'({root_q, ge});
                    if (bit_q != '0) bit_q <= bit_q - 1'b1;
                end
                FIN: begin
                    y_q <= mode_q ? acc_q : SW'(root_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o  = (state_q != IDLE);
    assign bus.valid_o = valid_q;
    assign bus.y_bo    = y_q;

endmodule
